iop_queue: RTL and testbench

IOP_QUEUE -- requirements
Module: iop_queue

---
 rtl/iop_queue_pkg.sv | 17 +
 rtl/iop_queue_ram.sv | 29 ++
 rtl/iop_queue.sv | 101 ++++++++++
 tb/tb_iop_queue.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/iop_queue_pkg.sv
// Shared widths and defaults for the micro-op queue.
// An entry is {iop, init, arg} packed MSB-first.
package iop_queue_pkg;
  localparam int IOP_W          = 32;
  localparam int INIT_W         = 3;
  localparam int ARG_W          = 16;
  localparam int ENTRY_W        = IOP_W + INIT_W + ARG_W; // 51
  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_SF_BIT = 21;
  localparam int CNT_W          = 5;  // holds 0..16

  typedef struct packed {
    logic [IOP_W-1:0]  iop;
    logic [INIT_W-1:0] init;
    logic [ARG_W-1:0]  arg;
  } entry_t;
endpackage

// File: rtl/iop_queue_ram.sv
// Queue storage: DEPTH x ENTRY_W, one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational)
module iop_queue_ram
  import iop_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/iop_queue.sv
// Micro-op queue between decode and execute.
//   clk, a_rst            : clock, async active-low reset
//   id_feed_req, id_iop,
//   id_iop_init, id_arg   : decoder offers an entry
//   ex_feed_slot          : queue not full (registered state only)
//   ex_flush              : drop everything (wins over push/pop)
//   q_valid, q_iop,
//   q_init, q_arg         : head entry
//   ex_take               : execute consumes head
//   q_sf_pending          : some queued entry writes flags
//   q_count               : occupancy
module iop_queue
  import iop_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int SF_BIT = DEFAULT_SF_BIT
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              id_feed_req,
  input  logic [IOP_W-1:0]  id_iop,
  input  logic [INIT_W-1:0] id_iop_init,
  input  logic [ARG_W-1:0]  id_arg,
  output logic              ex_feed_slot,
  input  logic              ex_flush,
  output logic              q_valid,
  output logic [IOP_W-1:0]  q_iop,
  output logic [INIT_W-1:0] q_init,
  output logic [ARG_W-1:0]  q_arg,
  input  logic              ex_take,
  output logic              q_sf_pending,
  output logic [CNT_W-1:0]  q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, sf_cnt_q, sf_cnt_d;
  logic             push, pop, push_sf, pop_sf;
  entry_t           wr_ent, head;

  // Full blocks a push even if the head is taken in the same cycle.
  assign ex_feed_slot = (count_q < DEPTH_C);
  assign q_valid      = (count_q != '0);
  assign q_sf_pending = (sf_cnt_q != '0);
  assign q_count      = count_q;

  assign push    = id_feed_req & ex_feed_slot & ~ex_flush;
  assign pop     = ex_take & q_valid & ~ex_flush;
  assign push_sf = push & id_iop[SF_BIT];
  assign pop_sf  = pop & head.iop[SF_BIT];

  assign wr_ent = '{iop: id_iop, init: id_iop_init, arg: id_arg};
  assign q_iop  = head.iop;
  assign q_init = head.init;
  assign q_arg  = head.arg;

  iop_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_ent),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sf_cnt_d = sf_cnt_q;
    if (ex_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      sf_cnt_d = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (push_sf && !pop_sf)      sf_cnt_d = sf_cnt_q + CNT_W'(1);
      else if (pop_sf && !push_sf) sf_cnt_d = sf_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sf_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sf_cnt_q <= sf_cnt_d;
    end
  end
endmodule

// File: tb/tb_iop_queue.sv
// Scoreboard bench for iop_queue: the driver appends accepted words to a
// model queue at the commit edge; a negedge monitor compares DUT status and
// head against that queue and retires the head when a take is due.
module tb_iop_queue;
  localparam int DEPTH = 4;
  localparam int SF    = 21;

  typedef struct {
    logic [31:0] iop;
    logic [2:0]  ini;
    logic [15:0] arg;
  } ent_t;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic        id_feed_req = 1'b0;
  logic [31:0] id_iop = '0;
  logic [2:0]  id_iop_init = '0;
  logic [15:0] id_arg = '0;
  logic        ex_feed_slot;
  logic        ex_flush = 1'b0;
  logic        q_valid;
  logic [31:0] q_iop;
  logic [2:0]  q_init;
  logic [15:0] q_arg;
  logic        ex_take = 1'b0;
  logic        q_sf_pending;
  logic [4:0]  q_count;

  ent_t sb[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  iop_queue #(.DEPTH(DEPTH), .SF_BIT(SF)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .id_feed_req  (id_feed_req),
    .id_iop       (id_iop),
    .id_iop_init  (id_iop_init),
    .id_arg       (id_arg),
    .ex_feed_slot (ex_feed_slot),
    .ex_flush     (ex_flush),
    .q_valid      (q_valid),
    .q_iop        (q_iop),
    .q_init       (q_init),
    .q_arg        (q_arg),
    .ex_take      (ex_take),
    .q_sf_pending (q_sf_pending),
    .q_count      (q_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic model_sf();
    foreach (sb[i]) if (sb[i].iop[SF]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: status every cycle, head only when the model holds an entry.
  always @(negedge clk) begin
    chk("valid", 64'(q_valid), 64'(sb.size() != 0));
    chk("count", 64'(q_count), 64'(sb.size()));
    chk("feed_slot", 64'(ex_feed_slot), 64'(sb.size() < DEPTH));
    chk("sf_pending", 64'(q_sf_pending), 64'(model_sf()));
    if (sb.size() != 0) begin
      chk("head_iop", 64'(q_iop), 64'(sb[0].iop));
      chk("head_init", 64'(q_init), 64'(sb[0].ini));
      chk("head_arg", 64'(q_arg), 64'(sb[0].arg));
      if (ex_take && !ex_flush && a_rst) void'(sb.pop_front());
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic req, input logic [31:0] iop, input logic [2:0] ini,
                     input logic [15:0] arg, input logic take, input logic flush);
    logic wp;
    ent_t e;
    id_feed_req = req; id_iop = iop; id_iop_init = ini; id_arg = arg;
    ex_take = take; ex_flush = flush;
    wp = req && !flush && (sb.size() < DEPTH);
    e.iop = iop; e.ini = ini; e.arg = arg;
    @(posedge clk);
    if (flush) sb.delete();
    else if (wp) sb.push_back(e);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b1;

    // Single push shows up one cycle later.
    cyc(1'b1, 32'h0000_0001, 3'd2, 16'h1234, 1'b0, 1'b0);
    chk("first_valid", 64'(q_valid), 64'd1);
    chk("first_iop", 64'(q_iop), 64'h1);
    chk("first_count", 64'(q_count), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Fill, then push+take at full: only the pop happens.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + i, 3'(i), 16'(i * 7), 1'b0, 1'b0);
    chk("full_count", 64'(q_count), 64'd4);
    chk("full_slot", 64'(ex_feed_slot), 64'd0);
    cyc(1'b1, 32'hBAD0_0000, 3'd7, 16'hBAD0, 1'b1, 1'b0);
    chk("fullpp_count", 64'(q_count), 64'd3);
    chk("fullpp_slot", 64'(ex_feed_slot), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Steady state at depth 2, pointers wrap several times.
    cyc(1'b1, 32'hA0, 3'd1, 16'hA0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA1, 3'd2, 16'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'hB0 + i, 3'(i), 16'hB0 + 16'(i), 1'b1, 1'b0);
    chk("steady_count", 64'(q_count), 64'd2);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Flag tracking.
    cyc(1'b1, 32'h0020_0000, 3'd0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 3'd0, 16'h1, 1'b0, 1'b0);
    chk("sf_set", 64'(q_sf_pending), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("sf_clear", 64'(q_sf_pending), 64'd0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Flush beats concurrent push and take.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0020_0010 + i, 3'd3, 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 3'd5, 16'hDEAD, 1'b1, 1'b1);
    chk("flush_count", 64'(q_count), 64'd0);
    chk("flush_valid", 64'(q_valid), 64'd0);
    chk("flush_sf", 64'(q_sf_pending), 64'd0);
    idle();

    // Async reset between edges.
    cyc(1'b1, 32'hC0, 3'd1, 16'hC0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC1, 3'd1, 16'hC1, 1'b0, 1'b0);
    id_feed_req = 1'b0;
    #1 a_rst = 1'b0;
    #1;
    chk("arst_valid", 64'(q_valid), 64'd0);
    chk("arst_slot", 64'(ex_feed_slot), 64'd1);
    chk("arst_count", 64'(q_count), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 a_rst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[SF] = ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 9) < 7, r, 3'($urandom), 16'($urandom),
          $urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
